// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice.
// Holds the fetch FSM states, the PC increment and the {pc, inst} prefetch entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits of a target are dropped.
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, inst} entries with a flush input.
// The head entry is readable combinationally; clear wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  fetch_entry_t             pushData_i,
  input  logic                     pop_i,
  output fetch_entry_t             headData_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wrPtr_q, wrPtr_d;
  logic [AW-1:0]  rdPtr_q, rdPtr_d;
  logic [AW:0]    count_q, count_d;
  logic           doPush, doPop, writeEn;

  always_comb begin
    doPush  = push_i && (count_q != (AW+1)'(DEPTH));
    doPop   = pop_i && (count_q != '0);
    writeEn = doPush && !clear_i;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (clear_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + AW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries covered by count_q are ever observed.
  always_ff @(posedge clk) begin
    if (writeEn) mem_q[wrPtr_q] <= pushData_i;
  end

  assign headData_o = mem_q[rdPtr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/inst_fetch_req.sv
// Instruction-fetch initiator: issues sequential word fetches, tags responses with their PC,
// buffers them in a prefetch FIFO for decode and handles redirects by flushing and dropping.
module inst_fetch_req
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        request_o,
  output logic [31:0] instAddr_o,
  input  logic [31:0] inst_i,
  input  logic        dataOk_i,
  input  logic        redirect_i,
  input  logic [31:0] redirectPc_i,
  output logic        instValid_o,
  input  logic        instReady_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   reqPc_q, reqPc_d;
  logic [CW-1:0] fifoCount;
  logic [CW:0]   occupancy;
  logic          hasCredit;
  logic          issue, push, pop;
  fetch_entry_t  pushEntry, headEntry;

  // The outstanding request reserves a FIFO slot, so a push can never find the FIFO full.
  assign occupancy = {1'b0, fifoCount} + {{CW{1'b0}}, (state_q != IDLE)};
  assign hasCredit = occupancy < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    reqPc_d = reqPc_q;
    issue   = 1'b0;
    push    = 1'b0;
    if (redirect_i) begin
      pc_d = alignPc(redirectPc_i);
      case (state_q)
        WAIT:    state_d = dataOk_i ? IDLE : DROP;
        DROP:    state_d = dataOk_i ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (hasCredit) begin
            issue   = 1'b1;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (dataOk_i) begin
            push = 1'b1;
            if (hasCredit) issue = 1'b1;
            else           state_d = IDLE;
          end
        end
        DROP: begin
          if (dataOk_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (issue) begin
      pc_d    = pc_q + PC_STEP;
      reqPc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      reqPc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      reqPc_q <= reqPc_d;
    end
  end

  assign pushEntry = '{pc: reqPc_q, inst: inst_i};

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (redirect_i),
    .push_i    (push),
    .pushData_i(pushEntry),
    .pop_i     (pop),
    .headData_o(headEntry),
    .count_o   (fifoCount)
  );

  // Outputs read as zero whenever they carry nothing, which also covers the reset state.
  assign request_o   = issue && !reset;
  assign instAddr_o  = request_o ? pc_q : 32'h0;
  assign instValid_o = (fifoCount != '0) && !redirect_i;
  assign pop         = instValid_o && instReady_i;
  assign inst_o      = instValid_o ? headEntry.inst : 32'h0;
  assign pc_o        = instValid_o ? headEntry.pc : 32'h0;

endmodule

// File: tb/tb_inst_fetch_req.sv
// Self-checking bench for inst_fetch_req: a ROM model answers fetches (word i = A000_0000 + i)
// and a PC-stream reference model predicts every request address and delivered {pc, inst}.
module tb_inst_fetch_req;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        request, dataOk, redirect, instValid, instReady;
  logic [31:0] instAddr, instIn, redirectPc, instOut, pcOut;

  logic        wRequest, wDataOk, wValid;
  logic [31:0] wAddr, wInstIn, wInst, wPc;

  int checks = 0;
  int errors = 0;
  int romLat = 1;

  always #5 clk = ~clk;

  inst_fetch_req #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .request_o(request), .instAddr_o(instAddr),
    .inst_i(instIn), .dataOk_i(dataOk), .redirect_i(redirect), .redirectPc_i(redirectPc),
    .instValid_o(instValid), .instReady_i(instReady), .inst_o(instOut), .pc_o(pcOut)
  );

  inst_fetch_req #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_wrap (
    .clk(clk), .reset(reset), .request_o(wRequest), .instAddr_o(wAddr),
    .inst_i(wInstIn), .dataOk_i(wDataOk), .redirect_i(1'b0), .redirectPc_i(32'h0),
    .instValid_o(wValid), .instReady_i(1'b1), .inst_o(wInst), .pc_o(wPc)
  );

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  // ROM model: answers each request after romLat cycles (1 or 2).
  logic        ok1 = 1'b0, ok2 = 1'b0, wOk = 1'b0;
  logic [31:0] a1 = '0, a2 = '0, wA = '0;
  always @(posedge clk) begin
    ok1 <= request;
    a1  <= instAddr;
    ok2 <= ok1;
    a2  <= a1;
    wOk <= wRequest;
    wA  <= wAddr;
  end
  assign dataOk  = (romLat == 2) ? ok2 : ok1;
  assign instIn  = romWord((romLat == 2) ? a2 : a1);
  assign wDataOk = wOk;
  assign wInstIn = romWord(wA);

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic doReset(input logic ready);
    reset      = 1'b1;
    redirect   = 1'b0;
    redirectPc = 32'h0;
    instReady  = ready;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; instReady = 1'b1; redirectPc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL reset_request got %b exp 0", request); end
    checks++; if (instAddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h exp 0", instAddr); end
    checks++; if (instValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", instValid); end
    checks++; if (instOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst got %h exp 0", instOut); end
    checks++; if (pcOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h exp 0", pcOut); end
  endtask

  task automatic test_stream();
    int first = -1;
    int n = 0;
    logic [31:0] expPc = 32'h0;
    romLat = 1;
    doReset(1'b1);
    checks++; if (request !== 1'b1) begin errors++; $display("[TB] FAIL stream_first_req got %b exp 1", request); end
    checks++; if (instAddr !== 32'h0) begin errors++; $display("[TB] FAIL stream_first_addr got %h exp 0", instAddr); end
    for (int c = 0; c < 20; c++) begin
      if (instValid) begin
        if (first < 0) first = c;
        checks++; if (pcOut !== expPc) begin errors++; $display("[TB] FAIL stream_pc got %h exp %h", pcOut, expPc); end
        checks++; if (instOut !== romWord(expPc)) begin errors++; $display("[TB] FAIL stream_inst got %h exp %h", instOut, romWord(expPc)); end
        expPc += 32'd4;
        n++;
      end
      tick(); settle();
    end
    checks++; if (first !== 2) begin errors++; $display("[TB] FAIL stream_latency got %0d exp 2", first); end
    checks++; if (n !== 18) begin errors++; $display("[TB] FAIL stream_throughput got %0d exp 18", n); end
  endtask

  task automatic test_backpressure();
    int reqs = 0;
    int pops = 0;
    bit sawResume = 0;
    romLat = 1;
    doReset(1'b0);
    for (int c = 0; c < 12; c++) begin
      if (request) begin
        checks++; if (instAddr !== 32'(4 * reqs)) begin errors++; $display("[TB] FAIL bp_addr got %h exp %h", instAddr, 32'(4 * reqs)); end
        reqs++;
      end
      tick(); settle();
    end
    checks++; if (reqs !== 4) begin errors++; $display("[TB] FAIL bp_req_count got %0d exp 4", reqs); end
    checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL bp_held got %b exp 0", request); end
    instReady = 1'b1;
    settle();
    for (int c = 0; c < 20 && pops < 5; c++) begin
      if (request && !sawResume) begin
        sawResume = 1;
        checks++; if (instAddr !== 32'h10) begin errors++; $display("[TB] FAIL bp_resume got %h exp 10", instAddr); end
      end
      if (instValid) begin
        checks++; if (pcOut !== 32'(4 * pops)) begin errors++; $display("[TB] FAIL bp_pop_pc got %h exp %h", pcOut, 32'(4 * pops)); end
        checks++; if (instOut !== romWord(32'(4 * pops))) begin errors++; $display("[TB] FAIL bp_pop_inst got %h exp %h", instOut, romWord(32'(4 * pops))); end
        pops++;
      end
      tick(); settle();
    end
    checks++; if (pops !== 5) begin errors++; $display("[TB] FAIL bp_pops got %0d exp 5", pops); end
  endtask

  task automatic test_redirect_drop();
    bit got = 0;
    romLat = 2;
    doReset(1'b1);
    tick();
    redirect = 1'b1; redirectPc = 32'h0000_0103;
    settle();
    checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL drop_redir_req got %b exp 0", request); end
    checks++; if (instValid !== 1'b0) begin errors++; $display("[TB] FAIL drop_redir_valid got %b exp 0", instValid); end
    tick();
    redirect = 1'b0;
    settle();
    checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL drop_wait_req got %b exp 0", request); end
    tick(); settle();
    checks++; if (request !== 1'b1) begin errors++; $display("[TB] FAIL drop_new_req got %b exp 1", request); end
    checks++; if (instAddr !== 32'h100) begin errors++; $display("[TB] FAIL drop_new_addr got %h exp 100", instAddr); end
    for (int c = 0; c < 12 && !got; c++) begin
      if (instValid) begin
        got = 1;
        checks++; if (pcOut !== 32'h100) begin errors++; $display("[TB] FAIL drop_first_pc got %h exp 100", pcOut); end
        checks++; if (instOut !== romWord(32'h100)) begin errors++; $display("[TB] FAIL drop_first_inst got %h exp %h", instOut, romWord(32'h100)); end
      end
      tick(); settle();
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL drop_timeout got 0 exp 1"); end
  endtask

  task automatic test_redirect_flush();
    bit found = 0;
    bit got = 0;
    romLat = 1;
    doReset(1'b0);
    for (int c = 0; c < 20 && !found; c++) begin
      if (request && instAddr == 32'hC) found = 1;
      else begin tick(); settle(); end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL flush_setup got 0 exp 1"); end
    tick();
    redirect = 1'b1; redirectPc = 32'h0000_0200;
    settle();
    checks++; if (instValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_redir_valid got %b exp 0", instValid); end
    checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL flush_redir_req got %b exp 0", request); end
    tick();
    redirect = 1'b0;
    settle();
    checks++; if (instValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty got %b exp 0", instValid); end
    checks++; if (request !== 1'b1) begin errors++; $display("[TB] FAIL flush_req got %b exp 1", request); end
    checks++; if (instAddr !== 32'h200) begin errors++; $display("[TB] FAIL flush_addr got %h exp 200", instAddr); end
    instReady = 1'b1;
    settle();
    for (int c = 0; c < 10 && !got; c++) begin
      if (instValid) begin
        got = 1;
        checks++; if (pcOut !== 32'h200) begin errors++; $display("[TB] FAIL flush_first_pc got %h exp 200", pcOut); end
      end
      tick(); settle();
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL flush_timeout got 0 exp 1"); end
  endtask

  task automatic test_wrap();
    logic [31:0] expReq = 32'hFFFF_FFF8;
    logic [31:0] expDel = 32'hFFFF_FFF8;
    int nReq = 0;
    int nDel = 0;
    doReset(1'b1);
    for (int c = 0; c < 10; c++) begin
      if (wRequest) begin
        checks++; if (wAddr !== expReq) begin errors++; $display("[TB] FAIL wrap_addr got %h exp %h", wAddr, expReq); end
        expReq += 32'd4;
        nReq++;
      end
      if (wValid) begin
        checks++; if (wPc !== expDel) begin errors++; $display("[TB] FAIL wrap_pc got %h exp %h", wPc, expDel); end
        checks++; if (wInst !== romWord(expDel)) begin errors++; $display("[TB] FAIL wrap_inst got %h exp %h", wInst, romWord(expDel)); end
        expDel += 32'd4;
        nDel++;
      end
      tick(); settle();
    end
    checks++; if (nReq < 3 || nDel < 3) begin errors++; $display("[TB] FAIL wrap_count got %0d/%0d exp >=3", nReq, nDel); end
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    romLat = 1;
    doReset(1'b1);
    repeat (4) begin tick(); settle(); end
    checks++; if (request !== 1'b1) begin errors++; $display("[TB] FAIL rmid_precond got %b exp 1", request); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL rmid_req got %b exp 0", request); end
    checks++; if (instAddr !== 32'h0) begin errors++; $display("[TB] FAIL rmid_addr got %h exp 0", instAddr); end
    checks++; if (instValid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid got %b exp 0", instValid); end
    checks++; if (instOut !== 32'h0) begin errors++; $display("[TB] FAIL rmid_inst got %h exp 0", instOut); end
    checks++; if (pcOut !== 32'h0) begin errors++; $display("[TB] FAIL rmid_pc got %h exp 0", pcOut); end
    reset = 1'b0;
    #1;
    checks++; if (request !== 1'b1 || instAddr !== 32'h0) begin errors++; $display("[TB] FAIL rmid_restart got %b/%h exp 1/0", request, instAddr); end
    for (int c = 0; c < 10 && !got; c++) begin
      if (instValid) begin
        got = 1;
        checks++; if (pcOut !== 32'h0) begin errors++; $display("[TB] FAIL rmid_first_pc got %h exp 0", pcOut); end
        checks++; if (instOut !== 32'hA000_0000) begin errors++; $display("[TB] FAIL rmid_first_inst got %h exp a0000000", instOut); end
      end
      tick(); settle();
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL rmid_timeout got 0 exp 1"); end
  endtask

  task automatic test_random();
    for (int lat = 1; lat <= 2; lat++) begin
      logic [31:0] expDel = 32'h0;
      logic [31:0] nextReq = 32'h0;
      int pops = 0;
      romLat = lat;
      doReset(1'b1);
      for (int c = 0; c < 600; c++) begin
        instReady  = ($urandom_range(0, 3) != 0);
        redirect   = ($urandom_range(0, 15) == 0);
        redirectPc = $urandom;
        settle();
        if (redirect) begin
          checks++; if (instValid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_redir_valid got %b exp 0", instValid); end
          checks++; if (request !== 1'b0) begin errors++; $display("[TB] FAIL rnd_redir_req got %b exp 0", request); end
        end
        if (request) begin
          checks++; if (instAddr !== nextReq) begin errors++; $display("[TB] FAIL rnd_addr got %h exp %h", instAddr, nextReq); end
          nextReq += 32'd4;
        end
        if (instValid && instReady) begin
          checks++; if (pcOut !== expDel) begin errors++; $display("[TB] FAIL rnd_pc got %h exp %h", pcOut, expDel); end
          checks++; if (instOut !== romWord(expDel)) begin errors++; $display("[TB] FAIL rnd_inst got %h exp %h", instOut, romWord(expDel)); end
          expDel += 32'd4;
        end
        if (redirect) begin
          expDel  = redirectPc & ~32'h3;
          nextReq = redirectPc & ~32'h3;
        end
        tick();
      end
      redirect  = 1'b0;
      instReady = 1'b1;
      settle();
      for (int c = 0; c < 30 && pops < 5; c++) begin
        if (instValid) begin
          checks++; if (pcOut !== expDel) begin errors++; $display("[TB] FAIL rnd_drain_pc got %h exp %h", pcOut, expDel); end
          expDel += 32'd4;
          pops++;
        end
        tick(); settle();
      end
      checks++; if (pops !== 5) begin errors++; $display("[TB] FAIL rnd_drain got %0d exp 5", pops); end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    instReady  = 1'b0;
    redirect   = 1'b0;
    redirectPc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
